ioctl_router: RTL and testbench

//  Routes the HPS ioctl download byte stream to NREG target regions by address window, replacing the

---
 rtl/ioctl_router_pkg.sv | 22 ++
 rtl/ioctl_fifo.sv | 43 ++++
 rtl/ioctl_router.sv | 161 ++++++++++++++++
 tb/tb_ioctl_router.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_router_pkg.sv
// Shared types and limits for the ioctl download router.
package ioctl_router_pkg;

  localparam int MAX_NREG  = 8;
  localparam int RGN_IDX_W = 3;
  localparam int MAX_OFS_W = 32;
  localparam int DROP_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [RGN_IDX_W-1:0] region;
    logic [MAX_OFS_W-1:0] ofs;
    logic [7:0]           data;
  } rgn_entry_t;

endpackage

// File: rtl/ioctl_fifo.sv
// Small synchronous FIFO with occupancy count; caller guarantees no push when full or pop when empty.
module ioctl_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/ioctl_router.sv
// Routes the hps_io download stream to NREG address windows through a FIFO with backpressure.
module ioctl_router
  import ioctl_router_pkg::*;
#(
  parameter int                     NREG   = 2,
  parameter int                     ADDR_W = 25,
  parameter int                     OFS_W  = 20,
  parameter int                     DEPTH  = 4,
  parameter logic [7:0]             INDEX  = 8'd0,
  parameter logic [NREG*ADDR_W-1:0] BASE   = {25'd614400, 25'd0},
  parameter logic [NREG*ADDR_W-1:0] SIZE   = {25'd4096, 25'd614400}
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  output logic [NREG-1:0]   rgn_active,
  output logic [NREG-1:0]   rgn_wr,
  input  logic [NREG-1:0]   rgn_ack,
  output logic [OFS_W-1:0]  rgn_ofs,
  output logic [7:0]        rgn_data,
  output logic              done,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = $bits(rgn_entry_t);

  if (NREG < 1 || NREG > MAX_NREG) begin : g_bad_nreg
    $error("ioctl_router: NREG must be 1..%0d", MAX_NREG);
  end
  if (OFS_W > ADDR_W || OFS_W >= MAX_OFS_W) begin : g_bad_ofs_w
    $error("ioctl_router: OFS_W too wide");
  end

  logic [NREG-1:0]      hit;
  logic [ADDR_W:0]      diff [NREG];
  logic [RGN_IDX_W-1:0] sel_idx;
  logic [OFS_W-1:0]     sel_ofs;
  logic                 any_hit;

  // addr - base in ADDR_W+1 bits: an address below the base borrows into the MSB and can never be < size.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_decode
    assign diff[gi] = {1'b0, ioctl_addr} - {1'b0, BASE[gi*ADDR_W +: ADDR_W]};
    assign hit[gi]  = diff[gi] < {1'b0, SIZE[gi*ADDR_W +: ADDR_W]};
    if (SIZE[gi*ADDR_W +: ADDR_W] > (64'd1 << OFS_W)) begin : g_size_err
      $error("ioctl_router: region %0d larger than offset range", gi);
    end
  end

  always_comb begin
    sel_idx = '0;
    sel_ofs = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_idx = RGN_IDX_W'(i);
        sel_ofs = diff[i][OFS_W-1:0];
      end
    end
  end
  assign any_hit = |hit;

  logic             dl_prev_reg, out_valid_reg, wait_reg, done_reg;
  rgn_entry_t       out_entry_reg;
  logic [NREG-1:0]  rgn_active_reg;
  logic [DROP_W-1:0] drop_cnt_reg, drop_cnt_next;
  state_t           state_reg;
  logic [CNT_W-1:0] fifo_count, total, total_next;
  logic [ENTRY_W-1:0] fifo_head;
  rgn_entry_t       entry_in;
  logic             dl_rise, dl_fall, wr_ok, full, push, drop, fire, load;

  assign dl_rise  = ioctl_download & ~dl_prev_reg;
  assign dl_fall  = ~ioctl_download & dl_prev_reg;
  assign wr_ok    = ioctl_wr & ioctl_download & (ioctl_index == INDEX);
  // Occupancy counts the output register as the FIFO head slot.
  assign total    = fifo_count + CNT_W'(out_valid_reg);
  assign full     = total >= CNT_W'(DEPTH);
  assign push     = wr_ok & any_hit & ~full;
  assign drop     = wr_ok & (~any_hit | full);
  assign fire     = |(rgn_wr & rgn_ack);
  assign load     = (fifo_count != '0) & (~out_valid_reg | fire);
  assign total_next = total + CNT_W'(push) - CNT_W'(fire);
  assign entry_in = {sel_idx, MAX_OFS_W'(sel_ofs), ioctl_dout};

  always_comb begin
    drop_cnt_next = dl_rise ? '0 : drop_cnt_reg;
    if (drop && drop_cnt_next != '1) drop_cnt_next = drop_cnt_next + 1'b1;
  end

  ioctl_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .push   (push),
    .wr_data(entry_in),
    .pop    (load),
    .rd_data(fifo_head),
    .count  (fifo_count)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_prev_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_entry_reg  <= '0;
      wait_reg       <= 1'b0;
      rgn_active_reg <= '0;
      drop_cnt_reg   <= '0;
      state_reg      <= ST_IDLE;
      done_reg       <= 1'b0;
    end else begin
      dl_prev_reg  <= ioctl_download;
      wait_reg     <= total_next >= CNT_W'(DEPTH - 1);
      drop_cnt_reg <= drop_cnt_next;
      rgn_active_reg <= (dl_rise ? '0 : rgn_active_reg) |
                        (push ? (NREG'(1) << sel_idx) : '0);
      if (load) begin
        out_valid_reg <= 1'b1;
        out_entry_reg <= rgn_entry_t'(fifo_head);
      end else if (fire) begin
        out_valid_reg <= 1'b0;
      end
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE:  if (dl_rise) state_reg <= ST_RUN;
        ST_RUN:   if (dl_fall) state_reg <= ST_DRAIN;
        ST_DRAIN: begin
          if (dl_rise) begin
            state_reg <= ST_RUN;
          end else if (total_next == '0) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        default:  state_reg <= dl_rise ? ST_RUN : ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_wr
    assign rgn_wr[gi] = out_valid_reg & (out_entry_reg.region == RGN_IDX_W'(gi));
  end

  logic unused_ofs_bits;
  assign unused_ofs_bits = ^out_entry_reg.ofs[MAX_OFS_W-1:OFS_W];

  assign rgn_ofs    = out_entry_reg.ofs[OFS_W-1:0];
  assign rgn_data   = out_entry_reg.data;
  assign ioctl_wait = wait_reg;
  assign rgn_active = rgn_active_reg;
  assign done       = done_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_ioctl_router.sv
// Directed checks for ioctl_router: decode table, backpressure, drain/done and async reset.
module tb_ioctl_router;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;
  logic        ioctl_wait;
  logic [1:0]  rgn_active, rgn_wr, rgn_ack;
  logic [19:0] rgn_ofs;
  logic [7:0]  rgn_data;
  logic        done;
  logic [15:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  ioctl_router dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_index   (ioctl_index),
    .ioctl_wait    (ioctl_wait),
    .rgn_active    (rgn_active),
    .rgn_wr        (rgn_wr),
    .rgn_ack       (rgn_ack),
    .rgn_ofs       (rgn_ofs),
    .rgn_data      (rgn_data),
    .done          (done),
    .drop_cnt      (drop_cnt)
  );

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  data;
    logic [1:0]  exp_wr;
    logic [19:0] exp_ofs;
    logic [15:0] exp_drop;
    logic [1:0]  exp_active;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Honours ioctl_wait (bounded), then strobes one byte.
  task automatic push_byte(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    while (ioctl_wait && n < 200) begin
      tick();
      n++;
    end
    chk("wait_timeout", 64'(n >= 200), 64'd0);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0; rgn_ack = '0;

    //          idx    addr            data    wr     ofs         drop   active
    vecs[0] = '{8'd0, 25'd0,          8'hA5, 2'b01, 20'd0,      16'd0, 2'b01};
    vecs[1] = '{8'd0, 25'd614417,     8'h3C, 2'b10, 20'd17,     16'd0, 2'b11};
    vecs[2] = '{8'd0, 25'd618496,     8'h99, 2'b00, 20'd0,      16'd1, 2'b11};
    vecs[3] = '{8'd0, 25'd614399,     8'h5A, 2'b01, 20'd614399, 16'd1, 2'b11};
    vecs[4] = '{8'd0, 25'd618495,     8'h77, 2'b10, 20'd4095,   16'd1, 2'b11};
    vecs[5] = '{8'd0, 25'h1FFFFFF,    8'h11, 2'b00, 20'd0,      16'd2, 2'b11};
    vecs[6] = '{8'd1, 25'd0,          8'h22, 2'b00, 20'd0,      16'd2, 2'b11};

    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;

    // Idle after reset: everything quiet for 100 cycles.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_sys);
      chk("idle_outputs", 64'({ioctl_wait, done, rgn_wr, rgn_active, drop_cnt, rgn_ofs, rgn_data}), 64'd0);
    end

    // Single-byte decode table with ack held high.
    @(posedge clk_sys); #1;
    rgn_ack = 2'b11;
    ioctl_download = 1'b1;
    tick(); tick();
    for (int v = 0; v < 7; v++) begin
      ioctl_index = vecs[v].idx;
      ioctl_addr  = vecs[v].addr;
      ioctl_dout  = vecs[v].data;
      ioctl_wr    = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      chk("vec_latency", 64'(rgn_wr), 64'd0);
      @(posedge clk_sys);
      @(negedge clk_sys);
      $display("vec %0d addr=%0d data=%02h -> rgn_wr=%b ofs=%0d data=%02h drop=%0d active=%b",
               v, vecs[v].addr, vecs[v].data, rgn_wr, rgn_ofs, rgn_data, drop_cnt, rgn_active);
      chk("vec_rgn_wr", 64'(rgn_wr), 64'(vecs[v].exp_wr));
      if (vecs[v].exp_wr != 2'b00) begin
        chk("vec_ofs", 64'(rgn_ofs), 64'(vecs[v].exp_ofs));
        chk("vec_data", 64'(rgn_data), 64'(vecs[v].data));
      end
      chk("vec_drop", 64'(drop_cnt), 64'(vecs[v].exp_drop));
      chk("vec_active", 64'(rgn_active), 64'(vecs[v].exp_active));
      tick();
      ioctl_index = 8'd0;
    end

    // Fall with empty FIFO: one DRAIN cycle, then a single done pulse.
    ioctl_download = 1'b0;
    tick();
    chk("fall_done_early", 64'(done), 64'd0);
    tick();
    chk("fall_done_pulse", 64'(done), 64'd1);
    tick();
    chk("fall_done_clear", 64'(done), 64'd0);
    chk("drop_held", 64'(drop_cnt), 64'd2);

    // Backpressure: ack low, five writes.
    rgn_ack = 2'b00;
    ioctl_download = 1'b1;
    tick();
    chk("rise_drop_clr", 64'(drop_cnt), 64'd0);
    chk("rise_active_clr", 64'(rgn_active), 64'd0);
    push_byte(25'd0, 8'h10);
    chk("wait_after1", 64'(ioctl_wait), 64'd0);
    push_byte(25'd1, 8'h11);
    chk("wait_after2", 64'(ioctl_wait), 64'd0);
    push_byte(25'd2, 8'h12);
    chk("wait_after3", 64'(ioctl_wait), 64'd1);
    repeat (3) tick();
    chk("held_wr", 64'(rgn_wr), 64'd1);
    chk("held_ofs", 64'(rgn_ofs), 64'd0);
    chk("held_data", 64'(rgn_data), 64'h10);
    chk("held_wait", 64'(ioctl_wait), 64'd1);
    rgn_ack = 2'b11;
    fork
      begin
        push_byte(25'd3, 8'h13);
        push_byte(25'd4, 8'h14);
      end
      begin
        int got = 0;
        int cyc = 0;
        while (got < 5 && cyc < 100) begin
          @(negedge clk_sys);
          cyc++;
          if (|(rgn_wr & rgn_ack)) begin
            $display("bp deliver %0d ofs=%0d data=%02h", got, rgn_ofs, rgn_data);
            chk("bp_ofs", 64'(rgn_ofs), 64'(got));
            chk("bp_data", 64'(rgn_data), 64'(8'h10 + got));
            got++;
          end
        end
        chk("bp_count", 64'(got), 64'd5);
      end
    join
    repeat (3) tick();
    chk("bp_wait_low", 64'(ioctl_wait), 64'd0);
    chk("bp_drop", 64'(drop_cnt), 64'd0);
    chk("bp_empty", 64'(rgn_wr), 64'd0);

    // Drain with a slow target: done exactly once, the cycle after the last pop.
    rgn_ack = 2'b00;
    for (int k = 0; k < 3; k++) push_byte(25'd614400 + 25'(k), 8'h20 + 8'(k));
    ioctl_download = 1'b0;
    begin
      int last_fire = -1;
      int done_cyc  = -1;
      int done_n    = 0;
      int got       = 0;
      for (int c = 0; c < 60; c++) begin
        @(posedge clk_sys); #1;
        rgn_ack = (c % 4 == 3) ? 2'b11 : 2'b00;
        @(negedge clk_sys);
        if (|(rgn_wr & rgn_ack)) begin
          $display("drain deliver %0d cyc=%0d data=%02h", got, c, rgn_data);
          chk("drain_data", 64'(rgn_data), 64'(8'h20 + got));
          got++;
          last_fire = c;
        end
        if (done) begin
          done_n++;
          done_cyc = c;
        end
      end
      chk("drain_count", 64'(got), 64'd3);
      chk("drain_done_n", 64'(done_n), 64'd1);
      chk("drain_done_cyc", 64'(done_cyc), 64'(last_fire + 1));
    end

    // Asynchronous reset with entries queued.
    @(posedge clk_sys); #1;
    rgn_ack = 2'b00;
    ioctl_download = 1'b1;
    tick();
    push_byte(25'd5, 8'h30);
    push_byte(25'd614400, 8'h31);
    push_byte(25'h1000000, 8'h32);
    @(negedge clk_sys);
    chk("pre_rst_wr", 64'(rgn_wr), 64'd1);
    chk("pre_rst_active", 64'(rgn_active), 64'd3);
    chk("pre_rst_drop", 64'(drop_cnt), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async", 64'({rgn_wr, rgn_active, drop_cnt, ioctl_wait}), 64'd0);
    ioctl_download = 1'b0;
    rgn_ack = 2'b11;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_sys);
      chk("post_rst_quiet", 64'({rgn_wr, done, ioctl_wait}), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
